// File: rtl/reg_if_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_if_pkg                                                   |
// | Description : Shared types and helpers for the register-interface front    |
// |               end: bytes-per-word constant, byte-enable to bit-mask        |
// |               expansion, response payload struct and FSM state encoding.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reg_if_pkg;

  // Bytes per 32-bit register word.
  localparam int unsigned BW = 4;

  // Response payload held in the response register.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // IDLE: no response pending; RESP: response held until consumed.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rsp_state_e;

  // Expand one byte-enable bit into eight mask bits.
  function automatic logic [31:0] be_to_mask(input logic [BW-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < BW; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage : reg_if_pkg
`default_nettype wire

// File: rtl/reg_if_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_if_decode_if                                             |
// | Description : Bus-side request (req/gnt) and response (valid/ready)        |
// |               channels of the register-interface front end.                |
// |               Signal suffixes are given from the decoder's point of view.  |
// | Ports       : req_i, we_i, addr_i[AW-1:0], wdata_i[31:0], be_i[3:0]        |
// |               gnt_o, rsp_valid_o, rsp_ready_i, rdata_o[31:0], err_o        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface reg_if_decode_if #(
  parameter int unsigned AW = 8
);
  import reg_if_pkg::*;

  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic [BW-1:0] be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rdata_o;
  logic          err_o;

  // Bus initiator side.
  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rdata_o, err_o
  );

  // Decoder side.
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rdata_o, err_o
  );

endinterface : reg_if_decode_if
`default_nettype wire

// File: rtl/reg_if_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_if_decode                                                |
// | Description : Register-interface front end. Accepts one bus request at a   |
// |               time, decodes the word address into one-hot write/read       |
// |               strobes, merges byte-enabled partial writes with the current |
// |               register value and returns read data / error through a       |
// |               one-deep valid/ready response register.                      |
// | Ports       : clk_i, rst_ni (async, active-low)                            |
// |               bus      - reg_if_decode_if.slave (request + response)       |
// |               reg_we_o - one-hot write strobe to register storage          |
// |               reg_re_o - one-hot read strobe                               |
// |               reg_wd_o - merged write data                                 |
// |               reg_rd_i - current register values, reg i at [32i+31:32i]    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_if_decode
  import reg_if_pkg::*;
#(
  parameter int unsigned     AW      = 8,
  parameter int unsigned     NREG    = 8,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  reg_if_decode_if.slave       bus,
  output logic [NREG-1:0]      reg_we_o,
  output logic [NREG-1:0]      reg_re_o,
  output logic [31:0]          reg_wd_o,
  input  logic [NREG*32-1:0]   reg_rd_i
);

  localparam int unsigned c_IW = AW - 2;

  rsp_state_e      r_state;
  rsp_state_e      w_state_d;
  rsp_t            r_rsp;
  rsp_t            w_rsp_d;
  rsp_t            w_rsp_new;

  logic [c_IW-1:0] w_idx;
  logic [NREG-1:0] w_sel;
  logic            w_hit;
  logic            w_ro;
  logic [31:0]     w_cur;
  logic [31:0]     w_mask;
  logic            w_err;
  logic            w_gnt;
  logic            w_acc;
  logic            w_wr_ok;
  logic            w_rd_ok;

  assign w_idx = bus.addr_i[AW-1:2];

  // Address match: one-hot select, current value and read-only flag of the
  // addressed register. An index beyond NREG leaves w_hit low.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    w_ro  = 1'b0;
    w_cur = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(w_idx) == i) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
        w_ro     = RO_MASK[i];
        w_cur    = reg_rd_i[i*32 +: 32];
      end
    end
  end

  assign w_err = (bus.addr_i[1:0] != 2'b00)
               | ~w_hit
               | (bus.we_i & (bus.be_i == '0))
               | (bus.we_i & w_ro);

  // One outstanding transaction; a new one may enter as the old is consumed.
  assign w_gnt = (r_state == ST_IDLE) | bus.rsp_ready_i;
  assign w_acc = bus.req_i & w_gnt;

  // Strobes are additionally gated by rst_ni so nothing reaches storage
  // while reset is held, even though gnt_o reads high then.
  assign w_wr_ok = w_acc & bus.we_i  & ~w_err & rst_ni;
  assign w_rd_ok = w_acc & ~bus.we_i & ~w_err & rst_ni;

  assign w_mask   = be_to_mask(bus.be_i);
  assign reg_we_o = {NREG{w_wr_ok}} & w_sel;
  assign reg_re_o = {NREG{w_rd_ok}} & w_sel;
  assign reg_wd_o = w_wr_ok ? ((bus.wdata_i & w_mask) | (w_cur & ~w_mask))
                            : bus.wdata_i;

  // Read data is returned only for clean reads; writes and errors return 0.
  always_comb begin
    w_rsp_new       = '0;
    w_rsp_new.err   = w_err;
    w_rsp_new.rdata = (bus.we_i | w_err) ? 32'h0 : w_cur;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_d;
      r_rsp   <= w_rsp_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_rsp_d   = r_rsp;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_state_d = ST_RESP;
          w_rsp_d   = w_rsp_new;
        end
      end
      ST_RESP: begin
        // w_acc here implies rsp_ready_i: back-to-back reload.
        if (w_acc) begin
          w_rsp_d = w_rsp_new;
        end else if (bus.rsp_ready_i) begin
          w_state_d = ST_IDLE;
          w_rsp_d   = '0;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_rsp_d   = '0;
      end
    endcase
  end

  assign bus.gnt_o       = w_gnt;
  assign bus.rsp_valid_o = (r_state == ST_RESP);
  assign bus.rdata_o     = r_rsp.rdata;
  assign bus.err_o       = r_rsp.err;

endmodule : reg_if_decode
`default_nettype wire

// File: tb/tb_reg_if_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_if_decode                                             |
// | Description : Self-checking bench for reg_if_decode: table of directed     |
// |               single transactions plus hand-written sequences for write/   |
// |               read ordering, backpressure and reset mid-response.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_if_decode;

  localparam int unsigned    AW      = 8;
  localparam int unsigned    NREG    = 8;
  localparam logic [NREG-1:0] RO_MASK = 8'h01;

  localparam logic [NREG*32-1:0] c_INIT = {
    32'hCAFE0007, 32'hCAFE0006, 32'hCAFE0005, 32'hCAFE0004,
    32'hCAFE0003, 32'hCAFE0002, 32'h11223344, 32'hCAFE0000
  };

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic [NREG-1:0]    reg_we;
  logic [NREG-1:0]    reg_re;
  logic [31:0]        reg_wd;
  logic [NREG*32-1:0] reg_rd;
  logic               mem_load = 1'b1;
  logic               store_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  reg_if_decode_if #(.AW(AW)) bus ();

  reg_if_decode #(.AW(AW), .NREG(NREG), .RO_MASK(RO_MASK)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .bus      (bus),
    .reg_we_o (reg_we),
    .reg_re_o (reg_re),
    .reg_wd_o (reg_wd),
    .reg_rd_i (reg_rd)
  );

  always #5 clk = ~clk;

  // Stand-in for the per-field storage cells.
  always @(posedge clk) begin
    if (mem_load) begin
      reg_rd <= c_INIT;
    end else if (store_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_we[i]) reg_rd[i*32 +: 32] <= reg_wd;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  exp_we;
    logic [7:0]  exp_re;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic drive(input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.be_i    = be;
  endtask

  initial begin
    bus.req_i       = 1'b0;
    bus.we_i        = 1'b0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.be_i        = '0;
    bus.rsp_ready_i = 1'b1;

    //            we    addr   wdata         be    we     re     wd            rdata         err
    vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 8'h02, 8'h00, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 8'h04, 32'hAAAABBBB, 4'h3, 8'h02, 8'h00, 32'h1122BBBB, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 8'h1C, 32'h0,        4'hF, 8'h00, 8'h80, 32'h0,        32'hCAFE0007, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 32'h0,        4'hF, 8'h00, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{1'b0, 8'h05, 32'h0,        4'hF, 8'h00, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b1, 8'h08, 32'h12345678, 4'h0, 8'h00, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b1, 8'h00, 32'h12345678, 4'hF, 8'h00, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 8'h08, 32'h0,        4'h0, 8'h00, 8'h04, 32'h0,        32'hCAFE0002, 1'b0};
    vecs[8]  = '{1'b1, 8'h0C, 32'h12345678, 4'hA, 8'h08, 8'h00, 32'h12FE5603, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 8'h1C, 32'h000000AB, 4'h1, 8'h80, 8'h00, 32'hCAFE00AB, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h00, 8'h01, 32'h0,        32'hCAFE0000, 1'b0};
    vecs[11] = '{1'b0, 8'hFC, 32'h0,        4'hF, 8'h00, 8'h00, 32'h0,        32'h0,        1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_err",   32'(bus.err_o), 32'h0);
    chk("rst_gnt",   32'(bus.gnt_o), 32'h1);
    chk("rst_we",    32'(reg_we), 32'h0);
    chk("rst_re",    32'(reg_re), 32'h0);
    rst_ni   = 1'b1;
    mem_load = 1'b0;

    // Table of single transactions against static register contents.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt_o), 32'h1);
      chk($sformatf("v%0d_we", i),  32'(reg_we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_re", i),  32'(reg_re), 32'(vecs[i].exp_re));
      if (vecs[i].exp_we != 8'h00) chk($sformatf("v%0d_wd", i), reg_wd, vecs[i].exp_wd);
      @(negedge clk);
      bus.req_i = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(bus.rsp_valid_o), 32'h1);
      chk($sformatf("v%0d_rdata", i), bus.rdata_o, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i),   32'(bus.err_o), 32'(vecs[i].exp_err));
    end
    @(negedge clk);
    chk("idle_valid", 32'(bus.rsp_valid_o), 32'h0);

    // Write then read of the same register on back-to-back cycles.
    store_en = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h10, 32'h5555AAAA, 4'hF);
    #1 chk("ord_we", 32'(reg_we), 32'h10);
    @(negedge clk);
    drive(1'b0, 8'h10, 32'h0, 4'hF);
    #1;
    chk("ord_gnt", 32'(bus.gnt_o), 32'h1);
    chk("ord_re",  32'(reg_re), 32'h10);
    @(negedge clk);
    bus.req_i = 1'b0;
    chk("ord_rdata", bus.rdata_o, 32'h5555AAAA);
    chk("ord_err",   32'(bus.err_o), 32'h0);
    store_en = 1'b0;

    // Backpressure: response held while rsp_ready_i is low.
    @(negedge clk);
    drive(1'b0, 8'h1C, 32'h0, 4'hF);
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h08, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_gnt", k),   32'(bus.gnt_o), 32'h0);
      chk($sformatf("bp%0d_re", k),    32'(reg_re), 32'h0);
      chk($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid_o), 32'h1);
      chk($sformatf("bp%0d_rdata", k), bus.rdata_o, 32'hCAFE0007);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("bp_gnt", 32'(bus.gnt_o), 32'h1);
    chk("bp_re",  32'(reg_re), 32'h04);
    @(negedge clk);
    bus.req_i = 1'b0;
    chk("bp2_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("bp2_rdata", bus.rdata_o, 32'hCAFE0002);
    @(negedge clk);
    chk("bp_drain", 32'(bus.rsp_valid_o), 32'h0);

    // Reset mid-response (error response pending).
    drive(1'b0, 8'h20, 32'h0, 4'hF);
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h1C, 32'h0, 4'hF);
    chk("mr_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("mr_err",   32'(bus.err_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_async_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("mr_rst_re",      32'(reg_re), 32'h0);
    @(negedge clk);
    chk("mr_rst_re2", 32'(reg_re), 32'h0);
    bus.req_i = 1'b0;
    rst_ni    = 1'b1;
    #1;
    chk("mr_gnt", 32'(bus.gnt_o), 32'h1);
    chk("mr_err_clr", 32'(bus.err_o), 32'h0);
    chk("mr_valid_clr", 32'(bus.rsp_valid_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_reg_if_decode
`default_nettype wire
